alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer that runs 8x8 unsigned multiply (shift-add) and 8/8 unsigned divide (restoring) on the existing 8-bit ALU.
- It issues one ALU operation per clock and captures the 9-bit ALU result into internal product/remainder registers.
- It exposes a start/busy/done handshake to the CPU.
- It sits between the CPU and the ALU instance, driving the ALU's A, B, carry and aluop inputs so that no extra adder is needed.

## Interface
Parameters:
- N, 8, operand width; the algorithm, counter and ALU opcode encodings are defined for N=8 only.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- op  input  1  0 = multiply, 1 = divide; latched with start.
- a_in  input  8  multiplicand / dividend; latched with start.
- b_in  input  8  multiplier / divisor; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid in this cycle.
- result_lo  output  8  product[7:0] / quotient.
- result_hi  output  8  product[15:8] / remainder.
- div_by_zero  output  1  set with done when the divide had divisor 0; cleared on next accepted start.
- alu_op  output  4  ALU operation code.
- alu_a  output  8  ALU A operand.
- alu_b  output  8  ALU B operand.
- alu_carry  output  1  ALU carry input.
- alu_y  input  9  ALU result; {carry, value}.

## Operation
- States: IDLE, MUL_ADD, MUL_SHIFT, DIV_SHIFT, DIV_SUB. 3-bit iteration counter `it`.
- ALU codes used: ZERO=4'h0, LOAD_A=4'h1, ROL=4'h6, ROR=4'h7, SUB=4'hd, ADD=4'hc.

IDLE:
- ALU is driven with alu_op=ZERO, alu_a=0, alu_b=0, alu_carry=0.
- start=1 latches op, a_in and b_in, clears div_by_zero and sets it=0.
- Multiply: P_hi=0, P_lo=b_in, M=a_in, go to MUL_ADD.
- Divide with b_in!=0: R=0, Q=a_in, D=b_in, go to DIV_SHIFT.
- Divide with b_in==0: go straight to completion with result_lo=8'hFF, result_hi=a_in, div_by_zero=1.

MUL_ADD:
- alu_a=P_hi, alu_b=M.
- alu_op=ADD if P_lo[0], else LOAD_A.
- Capture P_hi<=alu_y[7:0] and c<=alu_y[8].

MUL_SHIFT:
- alu_op=ROR, alu_a=P_hi, alu_carry=c.
- P_hi<=alu_y[7:0]; P_lo<={alu_y[8],P_lo[7:1]}.
- If it==7, complete; otherwise it++ and go to MUL_ADD.

DIV_SHIFT:
- alu_op=ROL, alu_a=R, alu_carry=Q[7].
- R<=alu_y[7:0]; rmsb<=alu_y[8]; Q<={Q[6:0],1'b0}.

DIV_SUB:
- alu_op=SUB, alu_a=R, alu_b=D.
- If rmsb | ~alu_y[8]: R<=alu_y[7:0] and Q[0]<=1; otherwise leave R and Q unchanged.
- If it==7, complete; otherwise it++ and go to DIV_SHIFT.

Completion:
- result_lo/result_hi are loaded from P_lo/P_hi or from Q/R.
- done<=1, busy<=0, state<=IDLE.
- Results hold until the next completion.

Other rules:
- alu_* outputs are combinational from state and registers only, never from start.
- start while busy is ignored, with no queuing.

## Timing
- Reset: state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0, alu_op=4'h0, alu_a=0, alu_b=0, alu_carry=0.
- Reset mid-operation aborts immediately; no done pulse is produced.
- start sampled at edge T: busy=1 from T+1 through T+16, which covers 16 ALU cycles (8 iterations x 2).
- At edge T+17: done=1 and busy=0 for exactly one cycle.
- Divide by zero: done=1 at edge T+1; busy is never asserted.
- start in the done cycle is accepted, because the block is already IDLE; busy rises at the next edge and done falls.
- done is never high together with busy.

## Configuration
- SEQ_DIV_EN defined: divide path as described.
- SEQ_DIV_EN undefined:
  - DIV_SHIFT, DIV_SUB and D/R/Q/rmsb logic are removed.
  - op=1 with start gives done at T+1 with result_lo=0, result_hi=0 and div_by_zero=0.
  - busy is never asserted for op=1.

## Test plan
- Multiply 8'd13 x 8'd11 -> result_hi=8'h00, result_lo=8'h8F, done exactly 17 cycles after start, busy high 16 cycles.
- Multiply 8'hFF x 8'hFF -> result_hi=8'hFE, result_lo=8'h01; 8'h00 x 8'h7A -> 16'h0000.
- Divide 8'd200 / 8'd7 -> result_lo=8'h1C, result_hi=8'h04, div_by_zero=0; 8'd5 / 8'd9 -> quotient 0, remainder 5.
- Divide 8'h55 / 0 -> done at T+1, result_lo=8'hFF, result_hi=8'h55, div_by_zero=1, busy never high; next valid start clears div_by_zero.
- Pulse start with new operands at T+5 during a multiply -> ignored, original result returned.
- Second start in the done cycle -> accepted back-to-back.
- Drop reset low at T+8 of a divide -> all outputs reach reset values asynchronously, no done.
- After reset release, 8'd3 x 8'd4 -> 8'h0C.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Sequencer that runs 8x8 unsigned shift-add multiply and 8/8 restoring divide on an external 8-bit ALU.
// Optional divide path: define SEQ_DIV_EN to include it; otherwise op=1 completes at once with zero results.
module alu_muldiv_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         div_by_zero,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_carry,
  input  logic [N:0]   alu_y
);

  localparam logic [3:0] OP_ZERO = 4'h0, OP_LOAD_A = 4'h1, OP_ROL = 4'h6,
                         OP_ROR  = 4'h7, OP_ADD    = 4'hc;
`ifdef SEQ_DIV_EN
  localparam logic [3:0] OP_SUB  = 4'hd;
`endif

  typedef enum logic [2:0] {
    IDLE, MUL_ADD, MUL_SHIFT
`ifdef SEQ_DIV_EN
    , DIV_SHIFT, DIV_SUB
`endif
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   it_q, it_d;
  logic [N-1:0] phi_q, phi_d, plo_q, plo_d, m_q, m_d;
  logic         c_q, c_d;
  logic [N-1:0] lo_q, lo_d, hi_q, hi_d;
  logic         done_q, done_d, dbz_q, dbz_d;
`ifdef SEQ_DIV_EN
  logic [N-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic         rmsb_q, rmsb_d;
`endif

  always_comb begin
    state_d   = state_q;
    it_d      = it_q;
    phi_d     = phi_q;
    plo_d     = plo_q;
    m_d       = m_q;
    c_d       = c_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    alu_op    = OP_ZERO;
    alu_a     = '0;
    alu_b     = '0;
    alu_carry = 1'b0;
`ifdef SEQ_DIV_EN
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    rmsb_d    = rmsb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          it_d  = '0;
          dbz_d = 1'b0;
          if (!op) begin
            phi_d   = '0;
            plo_d   = b_in;
            m_d     = a_in;
            state_d = MUL_ADD;
          end else begin
`ifdef SEQ_DIV_EN
            if (b_in != '0) begin
              r_d     = '0;
              q_d     = a_in;
              d_d     = b_in;
              state_d = DIV_SHIFT;
            end else begin
              done_d = 1'b1;
              lo_d   = '1;
              hi_d   = a_in;
              dbz_d  = 1'b1;
            end
`else
            done_d = 1'b1;
            lo_d   = '0;
            hi_d   = '0;
`endif
          end
        end
      end
      MUL_ADD: begin
        alu_op  = plo_q[0] ? OP_ADD : OP_LOAD_A;
        alu_a   = phi_q;
        alu_b   = m_q;
        phi_d   = alu_y[N-1:0];
        c_d     = alu_y[N];
        state_d = MUL_SHIFT;
      end
      MUL_SHIFT: begin
        // Rotate {c, P_hi} right; the bit falling out of P_hi enters P_lo.
        alu_op    = OP_ROR;
        alu_a     = phi_q;
        alu_carry = c_q;
        phi_d     = alu_y[N-1:0];
        plo_d     = {alu_y[N], plo_q[N-1:1]};
        if (it_q == 3'd7) begin
          done_d  = 1'b1;
          lo_d    = plo_d;
          hi_d    = phi_d;
          state_d = IDLE;
        end else begin
          it_d    = it_q + 3'd1;
          state_d = MUL_ADD;
        end
      end
`ifdef SEQ_DIV_EN
      DIV_SHIFT: begin
        alu_op    = OP_ROL;
        alu_a     = r_q;
        alu_carry = q_q[N-1];
        r_d       = alu_y[N-1:0];
        rmsb_d    = alu_y[N];
        q_d       = {q_q[N-2:0], 1'b0};
        state_d   = DIV_SUB;
      end
      DIV_SUB: begin
        // A set rmsb means the 9-bit remainder already exceeds D, so borrow is irrelevant.
        alu_op = OP_SUB;
        alu_a  = r_q;
        alu_b  = d_q;
        if (rmsb_q | ~alu_y[N]) begin
          r_d    = alu_y[N-1:0];
          q_d[0] = 1'b1;
        end
        if (it_q == 3'd7) begin
          done_d  = 1'b1;
          lo_d    = q_d;
          hi_d    = r_d;
          state_d = IDLE;
        end else begin
          it_d    = it_q + 3'd1;
          state_d = DIV_SHIFT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      it_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      m_q     <= '0;
      c_q     <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIV_EN
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      rmsb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      it_q    <= it_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      m_q     <= m_d;
      c_q     <= c_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIV_EN
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      rmsb_q  <= rmsb_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: includes a behavioural 8-bit ALU, directed vector table, corner sequences
// and random operations checked against plain-arithmetic expectations.
module tb_alu_muldiv_seq;

`ifdef SEQ_DIV_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, op;
  logic [7:0] a_in, b_in;
  logic       busy, done, div_by_zero, alu_carry;
  logic [7:0] result_lo, result_hi, alu_a, alu_b;
  logic [3:0] alu_op;
  logic [8:0] alu_y;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry(alu_carry), .alu_y(alu_y)
  );

  always #5 clk = ~clk;

  // ALU: {carry/borrow, value}
  always_comb begin
    case (alu_op)
      4'h1:    alu_y = {1'b0, alu_a};
      4'h6:    alu_y = {alu_a[7], alu_a[6:0], alu_carry};
      4'h7:    alu_y = {alu_a[0], alu_carry, alu_a[7:1]};
      4'hc:    alu_y = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry};
      4'hd:    alu_y = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_carry};
      default: alu_y = 9'd0;
    endcase
  end

  typedef struct {
    logic       op;
    logic [7:0] a, b, lo, hi;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model(input logic o, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] lo, output logic [7:0] hi, output logic dbz, output int lat);
    int p;
    dbz = 1'b0;
    lat = 16;
    if (!o) begin
      p  = int'(a) * int'(b);
      lo = p[7:0];
      hi = p[15:8];
    end else if (!DIVEN) begin
      lo = 8'h00; hi = 8'h00; lat = 0;
    end else if (b == 8'd0) begin
      lo = 8'hFF; hi = a; dbz = 1'b1; lat = 0;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // lat = edges after the start edge until done is seen; 16 means done sampled high at edge T+17.
  task automatic do_op(input string nm, input logic o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] elo, input logic [7:0] ehi, input logic edbz,
                       input int elat, input int glitch);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy0"}, busy, elat > 0);
    chk({nm, "_done0"}, done, elat == 0);
    chk({nm, "_dbz0"}, div_by_zero, edbz);
    lat = 0; bcnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      chk({nm, "_excl"}, busy & done, 1'b0);
      if (done) seen = 1;
      else begin
        if (busy) bcnt++;
        if (lat == glitch) begin start = 1'b1; a_in = ~a; b_in = 8'h5A; end
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
      end
    end
    chk({nm, "_timeout"}, seen, 1'b1);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_busycnt"}, bcnt, elat);
    chk({nm, "_res"}, {result_hi, result_lo}, {ehi, elo});
    chk({nm, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    logic [7:0] elo, ehi, ra, rb;
    logic       edbz, ro;
    int         elat;

    tbl[0] = '{1'b0, 8'd13,  8'd11,  8'h8F, 8'h00, 1'b0, 16};
    tbl[1] = '{1'b0, 8'hFF,  8'hFF,  8'h01, 8'hFE, 1'b0, 16};
    tbl[2] = '{1'b0, 8'h00,  8'h7A,  8'h00, 8'h00, 1'b0, 16};
    tbl[3] = '{1'b1, 8'd200, 8'd7,   DIVEN ? 8'h1C : 8'h00, DIVEN ? 8'h04 : 8'h00, 1'b0, DIVEN ? 16 : 0};
    tbl[4] = '{1'b1, 8'd5,   8'd9,   8'h00, DIVEN ? 8'h05 : 8'h00, 1'b0, DIVEN ? 16 : 0};
    tbl[5] = '{1'b1, 8'h55,  8'h00,  DIVEN ? 8'hFF : 8'h00, DIVEN ? 8'h55 : 8'h00, DIVEN, 0};
    tbl[6] = '{1'b0, 8'd3,   8'd4,   8'h0C, 8'h00, 1'b0, 16};
    tbl[7] = '{1'b1, 8'hFF,  8'h01,  DIVEN ? 8'hFF : 8'h00, 8'h00, 1'b0, DIVEN ? 16 : 0};
    tbl[8] = '{1'b1, 8'h00,  8'h05,  8'h00, 8'h00, 1'b0, DIVEN ? 16 : 0};
    tbl[9] = '{1'b0, 8'h01,  8'hFF,  8'hFF, 8'h00, 1'b0, 16};

    reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    #1;
    chk("reset_state", {busy, done, result_lo, result_hi, div_by_zero, alu_op, alu_a, alu_b, alu_carry}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Consecutive do_op calls start in the previous done cycle, so every row is back-to-back.
    foreach (tbl[i])
      do_op($sformatf("row%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi,
            tbl[i].dbz, tbl[i].lat, -1);

    // New operands pulsed mid-multiply must be ignored.
    do_op("glitch", 1'b0, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 16, 5);

    // Reset mid-operation: outputs clear asynchronously and no done follows.
    @(negedge clk);
    start = 1'b1; op = DIVEN; a_in = 8'd200; b_in = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("midop_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("reset_async", {busy, done, result_lo, result_hi, div_by_zero, alu_op, alu_a, alu_b, alu_carry}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {busy, done}, 2'b00);
    end
    do_op("post_reset", 1'b0, 8'd3, 8'd4, 8'h0C, 8'h00, 1'b0, 16, -1);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(ro, ra, rb, elo, ehi, edbz, elat);
      do_op($sformatf("rnd%0d", i), ro, ra, rb, elo, ehi, edbz, elat, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
